ysyx_23060240_mc_ctrl: RTL

Multi-cycle execution controller for the RV32 core. It replaces the single-cycle flow, where fetch, execute, memory and writeback all complete in one clock, with a handshaked sequencer. The block owns the PC and instruction register, fetches over a valid/ready instruction bus and issues loads/stores over a valid/ready data bus. It gates register-file and CSR writes to a single writeback cycle and flags bus timeouts. The decode/ALU/BSU/CSR datapath stays combinational around it.

---
 rtl/ysyx_23060240_mc_pkg.sv | 17 +
 rtl/ysyx_23060240_bus_timer.sv | 31 +++
 rtl/ysyx_23060240_mc_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ysyx_23060240_mc_pkg.sv
// Shared types and constants for the multi-cycle execution controller.
package ysyx_23060240_mc_pkg;

   typedef enum logic [2:0] {
      FETCH,
      IWAIT,
      EXEC,
      MREQ,
      MWAIT,
      WB,
      ERROR
   } mc_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [1:0]  INST_ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/ysyx_23060240_bus_timer.sv
// Per-transaction cycle counter; expired fires on the last allowed cycle of a transaction.
module ysyx_23060240_bus_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam int W = $clog2(TIMEOUT + 1);
         logic [W-1:0] cnt;

         always_ff @(posedge clk) begin
            if (rst || clr)
               cnt <= '0;
            else if (en)
               cnt <= cnt + W'(1);
         end

         // cnt holds the number of cycles already spent, so this is the TIMEOUT-th cycle
         assign expired = en && (cnt == W'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/ysyx_23060240_mc_ctrl.sv
// Multi-cycle sequencer: owns pc/inst, runs fetch and load/store handshakes,
// and opens a single writeback cycle per retired instruction.
module ysyx_23060240_mc_ctrl
   import ysyx_23060240_mc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int              TIMEOUT  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [XLEN/8-1:0] dmem_wmask,
   input  logic              dmem_rsp_valid,
   input  logic [XLEN-1:0]   dmem_rsp_rdata,
   output logic [31:0]       inst,
   output logic [XLEN-1:0]   pc,
   input  logic              dp_mem_rd,
   input  logic              dp_mem_wr,
   input  logic [XLEN-1:0]   dp_mem_addr,
   input  logic [XLEN-1:0]   dp_mem_wdata,
   input  logic [XLEN/8-1:0] dp_mem_wmask,
   input  logic              dp_jump_en,
   input  logic [XLEN-1:0]   dp_jump_pc,
   input  logic              dp_rf_wen,
   input  logic              dp_csr_wen,
   output logic [XLEN-1:0]   load_data,
   output logic              rf_wen,
   output logic              csr_wen,
   output logic              commit,
   output logic [XLEN-1:0]   commit_pc,
   output logic              err
);

   mc_state_e       state, state_nxt;
   logic [XLEN-1:0] pc_q, load_data_q, commit_pc_q;
   logic [31:0]     inst_q;
   logic            tmr_clr, tmr_en, tmr_expired;
   logic            jump_bad, wb_ok, run;

   assign run      = !rst;
   assign jump_bad = dp_jump_en && ((dp_jump_pc[1:0] & INST_ALIGN_MASK) != 2'b00);

   assign tmr_en  = (state == FETCH) || (state == IWAIT) || (state == MREQ) || (state == MWAIT);
   assign tmr_clr = (state == EXEC) || (state == WB);

   ysyx_23060240_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= FETCH;
      else
         state <= state_nxt;
   end

   // A response arriving on the expiry cycle still wins over the timeout.
   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH:   if (tmr_expired) state_nxt = ERROR;
                  else if (imem_req_ready) state_nxt = IWAIT;
         IWAIT:   if (imem_rsp_valid) state_nxt = EXEC;
                  else if (tmr_expired) state_nxt = ERROR;
         EXEC:    if (dp_mem_rd && dp_mem_wr) state_nxt = ERROR;
                  else if (dp_mem_rd || dp_mem_wr) state_nxt = MREQ;
                  else state_nxt = WB;
         MREQ:    if (tmr_expired) state_nxt = ERROR;
                  else if (dmem_req_ready) state_nxt = MWAIT;
         MWAIT:   if (dmem_rsp_valid) state_nxt = WB;
                  else if (tmr_expired) state_nxt = ERROR;
         WB:      state_nxt = jump_bad ? ERROR : FETCH;
         ERROR:   state_nxt = ERROR;
         default: state_nxt = ERROR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         inst_q      <= '0;
         load_data_q <= '0;
         commit_pc_q <= '0;
      end else begin
         if (state == IWAIT && imem_rsp_valid) begin
            inst_q      <= imem_rsp_data;
            commit_pc_q <= pc_q;
         end
         if (state == MWAIT && dmem_rsp_valid && !dp_mem_wr)
            load_data_q <= dmem_rsp_rdata;
         if (state == WB && !jump_bad)
            pc_q <= dp_jump_en ? dp_jump_pc : pc_q + XLEN'(4);
      end
   end

   // Outputs are masked while rst is held so the first fetch appears only after release.
   assign wb_ok          = run && (state == WB) && !jump_bad;
   assign imem_req_valid = run && (state == FETCH);
   assign imem_addr      = pc_q;
   assign dmem_req_valid = run && (state == MREQ);
   assign dmem_we        = dp_mem_wr;
   assign dmem_addr      = dp_mem_addr;
   assign dmem_wdata     = dp_mem_wdata;
   assign dmem_wmask     = dp_mem_wmask;
   assign rf_wen         = wb_ok && dp_rf_wen;
   assign csr_wen        = wb_ok && dp_csr_wen;
   assign commit         = wb_ok;
   assign commit_pc      = commit_pc_q;
   assign err            = (state == ERROR);
   assign inst           = inst_q;
   assign pc             = pc_q;
   assign load_data      = load_data_q;

endmodule
